// File: rtl/ram_arbiter_pkg.sv
// rtl/ram_arbiter_pkg.sv - shared state encoding, size defaults and requester constants
package ram_arbiter_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int DEPTH_DEF  = 8;

  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    RESP = 2'd2
  } state_t;

  function automatic logic [1:0] req_onehot(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/ram_arbiter_if.sv
// rtl/ram_arbiter_if.sv - two-requester RAM access bus; requesters are master, arbiter is slave
interface ram_arbiter_if
  import ram_arbiter_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = $clog2(DEPTH_DEF)
);

  logic [1:0]        req;
  logic [1:0]        we;
  logic [ADDR_W-1:0] addr0;
  logic [ADDR_W-1:0] addr1;
  logic [DATA_W-1:0] wdata0;
  logic [DATA_W-1:0] wdata1;
  logic [1:0]        gnt;
  logic [1:0]        ack;
  logic [DATA_W-1:0] rdata;

  modport master (
    output req, we, addr0, addr1, wdata0, wdata1,
    input  gnt, ack, rdata
  );

  modport slave (
    input  req, we, addr0, addr1, wdata0, wdata1,
    output gnt, ack, rdata
  );

endinterface

// File: rtl/ram_core.sv
// rtl/ram_core.sv - DEPTH x DATA_W word storage, one load strobe, asynchronous read port
module ram_core
  import ram_arbiter_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              load,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout
);

  // Contents are deliberately left unreset; the arbiter alone owns the load strobe.
  logic [DATA_W-1:0] words_q [DEPTH];

  always_ff @(posedge clk) begin
    if (load) begin
      words_q[addr] <= din;
    end
  end

  assign dout = words_q[addr];

endmodule

// File: rtl/ram_arbiter.sv
// rtl/ram_arbiter.sv - two-requester single-port RAM arbiter (IDLE/XFER/RESP, 3 cycles per access)
// Define ARB_ROUND_ROBIN_EN for round-robin tie breaking; otherwise requester 0 always wins ties.
module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  ram_arbiter_if.slave    bus
);

  localparam int ADDR_W = $clog2(DEPTH);

  state_t            state_q, state_d;
  logic              win_q, win_d;
  logic              cap_we_q, cap_we_d;
  logic [ADDR_W-1:0] cap_addr_q, cap_addr_d;
  logic [DATA_W-1:0] cap_wdata_q, cap_wdata_d;
  logic [1:0]        gnt_q, gnt_d;
  logic [1:0]        ack_q, ack_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              pick;
  logic              ram_load;
  logic [DATA_W-1:0] ram_dout;

`ifdef ARB_ROUND_ROBIN_EN
  // prio_q names the requester that wins the next tie.
  logic prio_q, prio_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio_q <= REQ0;
    end else begin
      prio_q <= prio_d;
    end
  end

  always_comb begin
    pick = (bus.req == 2'b11) ? prio_q : bus.req[1];
  end
`else
  always_comb begin
    pick = bus.req[0] ? REQ0 : REQ1;
  end
`endif

  always_comb begin
    state_d     = state_q;
    win_d       = win_q;
    cap_we_d    = cap_we_q;
    cap_addr_d  = cap_addr_q;
    cap_wdata_d = cap_wdata_q;
    gnt_d       = gnt_q;
    ack_d       = 2'b00;
    rdata_d     = rdata_q;
    ram_load    = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
    prio_d      = prio_q;
`endif
    case (state_q)
      IDLE: begin
        gnt_d = 2'b00;
        if (bus.req != 2'b00) begin
          win_d       = pick;
          cap_we_d    = bus.we[pick];
          cap_addr_d  = pick ? bus.addr1 : bus.addr0;
          cap_wdata_d = pick ? bus.wdata1 : bus.wdata0;
          gnt_d       = req_onehot(pick);
          state_d     = XFER;
`ifdef ARB_ROUND_ROBIN_EN
          prio_d      = ~pick;
`endif
        end
      end
      XFER: begin
        // Only the captured request is used from here on; live bus inputs are ignored.
        ram_load = cap_we_q;
        if (!cap_we_q) begin
          rdata_d = ram_dout;
        end
        ack_d   = req_onehot(win_q);
        state_d = RESP;
      end
      RESP: begin
        gnt_d   = 2'b00;
        state_d = IDLE;
      end
      default: begin
        gnt_d   = 2'b00;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      win_q       <= REQ0;
      cap_we_q    <= 1'b0;
      cap_addr_q  <= '0;
      cap_wdata_q <= '0;
      gnt_q       <= 2'b00;
      ack_q       <= 2'b00;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      win_q       <= win_d;
      cap_we_q    <= cap_we_d;
      cap_addr_q  <= cap_addr_d;
      cap_wdata_q <= cap_wdata_d;
      gnt_q       <= gnt_d;
      ack_q       <= ack_d;
      rdata_q     <= rdata_d;
    end
  end

  ram_core #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_core (
    .clk  (clk),
    .load (ram_load),
    .addr (cap_addr_q),
    .din  (cap_wdata_q),
    .dout (ram_dout)
  );

  assign bus.gnt   = gnt_q;
  assign bus.ack   = ack_q;
  assign bus.rdata = rdata_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// tb/tb_ram_arbiter.sv - randomized self-checking bench for ram_arbiter against a transaction-level model
module tb_ram_arbiter;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  ram_arbiter_if #(.DATA_W(16), .ADDR_W(3)) bus ();

  ram_arbiter #(.DATA_W(16), .DEPTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  // Transaction-level reference: memory contents, last grantee, last read result.
  logic [15:0] mem_m [8];
  bit          known_m [8];
  int          last_gnt;
  logic [15:0] last_rd_m;
  bit          rd_known;

  // Optional input changes applied right after the capture edge.
  bit          chg_en = 1'b0;
  logic [1:0]  chg_req, chg_we;
  logic [2:0]  chg_a0, chg_a1;
  logic [15:0] chg_d0, chg_d1;

  function automatic int model_winner(input logic [1:0] rq);
    if (rq == 2'b01) return 0;
    if (rq == 2'b10) return 1;
`ifdef ARB_ROUND_ROBIN_EN
    return (last_gnt == 0) ? 1 : 0;
`else
    return 0;
`endif
  endfunction

  function automatic logic [1:0] exp_onehot(input int w);
    return (w == 1) ? 2'b10 : 2'b01;
  endfunction

  task automatic model_update(input int w, input logic wr, input logic [2:0] a, input logic [15:0] d);
    last_gnt = w;
    if (wr) begin
      mem_m[a]   = d;
      known_m[a] = 1'b1;
    end
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    bus.req = 2'b00;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    last_gnt  = -1;
    last_rd_m = 16'h0000;
    rd_known  = 1'b1;
  endtask

  task automatic run_txn(input logic [1:0] rq, input logic [1:0] w,
                         input logic [2:0] a0, input logic [2:0] a1,
                         input logic [15:0] d0, input logic [15:0] d1,
                         output int lat, output logic [1:0] ak,
                         output logic [1:0] gs, output logic [15:0] rd);
    @(posedge clk);
    #1;
    bus.req = rq; bus.we = w;
    bus.addr0 = a0; bus.addr1 = a1;
    bus.wdata0 = d0; bus.wdata1 = d1;
    @(posedge clk);
    #1;
    if (chg_en) begin
      bus.req = chg_req; bus.we = chg_we;
      bus.addr0 = chg_a0; bus.addr1 = chg_a1;
      bus.wdata0 = chg_d0; bus.wdata1 = chg_d1;
    end
    lat = 0; ak = 2'b00; gs = 2'b00; rd = 16'h0000;
    while (lat < 8 && ak == 2'b00) begin
      @(negedge clk);
      lat++;
      if (lat == 1) gs = bus.gnt;
      if (bus.ack != 2'b00) begin
        ak = bus.ack;
        rd = bus.rdata;
      end
    end
    bus.req = 2'b00;
  endtask

  task automatic monitor();
    logic [1:0] prev = 2'b00;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1) begin
        n_cmp++;
        if (!$onehot0(bus.gnt)) begin
          n_fail++; $display("FAIL gnt_onehot: gnt=%b required zero or one-hot", bus.gnt);
        end
        n_cmp++;
        if (!$onehot0(bus.ack)) begin
          n_fail++; $display("FAIL ack_onehot: ack=%b required zero or one-hot", bus.ack);
        end
        n_cmp++;
        if (bus.ack != 2'b00 && prev != 2'b00) begin
          n_fail++; $display("FAIL ack_width: ack=%b previous=%b required single-cycle pulse", bus.ack, prev);
        end
        if (bus.ack != 2'b00) begin
          n_cmp++;
          if (bus.gnt !== bus.ack) begin
            n_fail++; $display("FAIL gnt_during_ack: gnt=%b required %b", bus.gnt, bus.ack);
          end
        end
        prev = bus.ack;
      end else begin
        prev = 2'b00;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.req = 2'b00; bus.we = 2'b00;
    bus.addr0 = '0; bus.addr1 = '0; bus.wdata0 = '0; bus.wdata1 = '0;
    #1;
    n_cmp++; if (bus.gnt !== 2'b00) begin n_fail++; $display("FAIL reset_gnt: gnt=%b required 00", bus.gnt); end
    n_cmp++; if (bus.ack !== 2'b00) begin n_fail++; $display("FAIL reset_ack: ack=%b required 00", bus.ack); end
    n_cmp++; if (bus.rdata !== 16'h0000) begin n_fail++; $display("FAIL reset_rdata: rdata=%h required 0000", bus.rdata); end
    apply_reset();
    @(negedge clk);
    n_cmp++; if (bus.gnt !== 2'b00) begin n_fail++; $display("FAIL idle_gnt: gnt=%b required 00", bus.gnt); end
  endtask

  task automatic test_arbitration();
    int acks, cyc, prev_cyc, w;
    logic [1:0] e;
    apply_reset();
    @(posedge clk);
    #1;
    bus.req = 2'b11; bus.we = 2'b00; bus.addr0 = 3'd1; bus.addr1 = 3'd6;
    acks = 0; cyc = 0; prev_cyc = 0;
    while (acks < 4 && cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (bus.ack != 2'b00) begin
        w = model_winner(2'b11);
        e = exp_onehot(w);
        n_cmp++;
        if (bus.ack !== e) begin
          n_fail++; $display("FAIL arb_order[%0d]: ack=%b required %b", acks, bus.ack, e);
        end
        if (acks > 0) begin
          n_cmp++;
          if (cyc - prev_cyc != 3) begin
            n_fail++; $display("FAIL back_to_back[%0d]: spacing=%0d required 3", acks, cyc - prev_cyc);
          end
        end
        last_gnt = w;
        prev_cyc = cyc;
        acks++;
        if (acks == 4) bus.req = 2'b00;
      end
    end
    bus.req = 2'b00;
    n_cmp++;
    if (acks != 4) begin n_fail++; $display("FAIL arb_timeout: acks=%0d required 4", acks); end
    rd_known = 1'b0;
  endtask

  task automatic test_fill();
    int lat, w;
    logic [1:0] ak, gs;
    logic [15:0] rd, d;
    for (int a = 0; a < 8; a++) begin
      w = int'($urandom_range(0, 1));
      d = 16'($urandom);
      run_txn(exp_onehot(w), 2'b11, 3'(a), 3'(a), d, d, lat, ak, gs, rd);
      n_cmp++; if (ak !== exp_onehot(w)) begin n_fail++; $display("FAIL fill_ack[%0d]: ack=%b required %b", a, ak, exp_onehot(w)); end
      n_cmp++; if (lat != 2) begin n_fail++; $display("FAIL fill_latency[%0d]: lat=%0d required 2", a, lat); end
      model_update(w, 1'b1, 3'(a), d);
    end
  endtask

  task automatic test_write_read();
    int lat;
    logic [1:0] ak, gs;
    logic [15:0] rd;
    run_txn(2'b01, 2'b01, 3'd3, 3'd0, 16'hA5A5, 16'h0000, lat, ak, gs, rd);
    n_cmp++; if (ak !== 2'b01) begin n_fail++; $display("FAIL wr_ack: ack=%b required 01", ak); end
    n_cmp++; if (lat != 2) begin n_fail++; $display("FAIL wr_latency: lat=%0d required 2", lat); end
    model_update(0, 1'b1, 3'd3, 16'hA5A5);
    run_txn(2'b01, 2'b00, 3'd3, 3'd0, 16'h0000, 16'h0000, lat, ak, gs, rd);
    n_cmp++; if (ak !== 2'b01) begin n_fail++; $display("FAIL rd_ack: ack=%b required 01", ak); end
    n_cmp++; if (lat != 2) begin n_fail++; $display("FAIL rd_latency: lat=%0d required 2", lat); end
    n_cmp++; if (rd !== 16'hA5A5) begin n_fail++; $display("FAIL rd_data: rdata=%h required a5a5", rd); end
    model_update(0, 1'b0, 3'd3, 16'h0000);
    last_rd_m = 16'hA5A5; rd_known = 1'b1;
  endtask

  task automatic test_cross();
    int lat;
    logic [1:0] ak, gs;
    logic [15:0] rd;
    run_txn(2'b10, 2'b10, 3'd0, 3'd7, 16'h0000, 16'h1234, lat, ak, gs, rd);
    n_cmp++; if (ak !== 2'b10) begin n_fail++; $display("FAIL cross_wr_ack: ack=%b required 10", ak); end
    model_update(1, 1'b1, 3'd7, 16'h1234);
    for (int a = 7; a >= 0; a--) begin
      run_txn(2'b01, 2'b00, 3'(a), 3'd0, 16'h0000, 16'h0000, lat, ak, gs, rd);
      n_cmp++;
      if (rd !== mem_m[a]) begin n_fail++; $display("FAIL cross_rd[%0d]: rdata=%h required %h", a, rd, mem_m[a]); end
      model_update(0, 1'b0, 3'(a), 16'h0000);
      last_rd_m = mem_m[a]; rd_known = 1'b1;
    end
  endtask

  task automatic test_capture();
    int lat;
    logic [1:0] ak, gs;
    logic [15:0] rd, d;
    d = 16'h3C3C;
    chg_en = 1'b1; chg_req = 2'b01; chg_we = 2'b01;
    chg_a0 = 3'd5; chg_a1 = 3'd5; chg_d0 = 16'hFFFF; chg_d1 = 16'hFFFF;
    run_txn(2'b01, 2'b01, 3'd1, 3'd0, d, 16'h0000, lat, ak, gs, rd);
    chg_en = 1'b0;
    n_cmp++; if (ak !== 2'b01) begin n_fail++; $display("FAIL cap_ack: ack=%b required 01", ak); end
    model_update(0, 1'b1, 3'd1, d);
    run_txn(2'b01, 2'b00, 3'd1, 3'd0, 16'h0000, 16'h0000, lat, ak, gs, rd);
    n_cmp++; if (rd !== d) begin n_fail++; $display("FAIL cap_target: rdata=%h required %h", rd, d); end
    run_txn(2'b01, 2'b00, 3'd5, 3'd0, 16'h0000, 16'h0000, lat, ak, gs, rd);
    n_cmp++; if (rd !== mem_m[5]) begin n_fail++; $display("FAIL cap_other: rdata=%h required %h", rd, mem_m[5]); end
    last_gnt = 0;
    last_rd_m = mem_m[5]; rd_known = 1'b1;
  endtask

  task automatic test_reset_mid_xfer();
    int lat;
    bit seen;
    logic [1:0] ak, gs;
    logic [15:0] rd, old_v, new_v;
    old_v = mem_m[2];
    new_v = ~old_v;
    @(posedge clk);
    #1;
    bus.req = 2'b01; bus.we = 2'b01; bus.addr0 = 3'd2; bus.wdata0 = new_v;
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    n_cmp++; if (bus.gnt !== 2'b00) begin n_fail++; $display("FAIL rst_xfer_gnt: gnt=%b required 00", bus.gnt); end
    n_cmp++; if (bus.ack !== 2'b00) begin n_fail++; $display("FAIL rst_xfer_ack: ack=%b required 00", bus.ack); end
    n_cmp++; if (bus.rdata !== 16'h0000) begin n_fail++; $display("FAIL rst_xfer_rdata: rdata=%h required 0000", bus.rdata); end
    bus.req = 2'b00;
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (bus.ack != 2'b00) seen = 1'b1;
    end
    n_cmp++; if (seen) begin n_fail++; $display("FAIL rst_dropped: ack seen=1 required 0"); end
    last_gnt = -1; last_rd_m = 16'h0000; rd_known = 1'b1;
    run_txn(2'b01, 2'b00, 3'd2, 3'd0, 16'h0000, 16'h0000, lat, ak, gs, rd);
    n_cmp++; if (lat != 2) begin n_fail++; $display("FAIL rst_first_latency: lat=%0d required 2", lat); end
    n_cmp++;
    if (rd !== old_v && rd !== new_v) begin
      n_fail++; $display("FAIL rst_word: rdata=%h required %h or %h", rd, old_v, new_v);
    end
    model_update(0, 1'b0, 3'd2, 16'h0000);
    known_m[2] = 1'b0;
    rd_known = 1'b0;
  endtask

  task automatic test_random();
    int lat, w;
    logic [1:0] ak, gs, rq, wv, e;
    logic [2:0] a0, a1, ea;
    logic [15:0] d0, d1, ed, rd;
    logic ewr;
    for (int i = 0; i < 60; i++) begin
      rq = 2'($urandom_range(1, 3));
      wv = 2'($urandom);
      a0 = 3'($urandom); a1 = 3'($urandom);
      d0 = 16'($urandom); d1 = 16'($urandom);
      chg_en = 1'($urandom);
      chg_req = 2'($urandom); chg_we = 2'($urandom);
      chg_a0 = 3'($urandom); chg_a1 = 3'($urandom);
      chg_d0 = 16'($urandom); chg_d1 = 16'($urandom);
      w = model_winner(rq);
      e = exp_onehot(w);
      ewr = wv[w];
      ea = (w == 1) ? a1 : a0;
      ed = (w == 1) ? d1 : d0;
      run_txn(rq, wv, a0, a1, d0, d1, lat, ak, gs, rd);
      n_cmp++; if (ak !== e) begin n_fail++; $display("FAIL rnd_ack[%0d]: ack=%b required %b", i, ak, e); end
      n_cmp++; if (gs !== e) begin n_fail++; $display("FAIL rnd_gnt[%0d]: gnt=%b required %b", i, gs, e); end
      n_cmp++; if (lat != 2) begin n_fail++; $display("FAIL rnd_latency[%0d]: lat=%0d required 2", i, lat); end
      if (ewr) begin
        if (rd_known) begin
          n_cmp++;
          if (rd !== last_rd_m) begin n_fail++; $display("FAIL rnd_rdata_hold[%0d]: rdata=%h required %h", i, rd, last_rd_m); end
        end
      end else if (known_m[ea]) begin
        n_cmp++;
        if (rd !== mem_m[ea]) begin n_fail++; $display("FAIL rnd_read[%0d]: addr=%0d rdata=%h required %h", i, ea, rd, mem_m[ea]); end
        last_rd_m = mem_m[ea]; rd_known = 1'b1;
      end else begin
        rd_known = 1'b0;
      end
      model_update(w, ewr, ea, ed);
    end
    chg_en = 1'b0;
  endtask

  initial begin
    for (int a = 0; a < 8; a++) begin
      mem_m[a] = 16'h0000;
      known_m[a] = 1'b0;
    end
    last_gnt = -1; last_rd_m = 16'h0000; rd_known = 1'b1;
    fork
      monitor();
    join_none
    test_reset();
    test_arbitration();
    test_fill();
    test_write_read();
    test_cross();
    test_capture();
    test_reset_mid_xfer();
    test_random();
    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
